// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared types and constants for the IF/DM unified-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_mem_arbiter_pkg;

  // One outstanding transaction: either idle, waiting for a fetch or data
  // response, or draining a fetch that a flush has made stale.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DROP   = 2'd3
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 64;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True in every state that owns the memory port.
  function automatic logic arb_is_waiting(input arb_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/gnt handshake on each port, rvalid is a 1-cycle pulse.
interface rv32_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Data port
  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view: serves the core, drives the memory.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // Environment view: core requesters plus the memory model.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/rv32_wait_timer.sv
// Counts cycles spent waiting for a memory response; flags the last allowed cycle.
// Latency: o_expire is combinational from the count, high on the TIMEOUT-th enabled cycle after clear.
// Backpressure: none; i_clr has priority over i_en.
module rv32_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Restart on every state change; advance while a transaction is waiting.
  // Expiry forces a state change, so the count never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-port memory between fetch and data stages, data first, one transaction in flight.
// Latency: request reaches memory combinationally; response returns in the same cycle as mem_rvalid.
// Backpressure: requesters hold until rvalid; stall holds the pipeline; a wait expires after TIMEOUT cycles.
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_halt,
  rv32_mem_arbiter_if.slave  io_bus,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_timeout_err
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_timeout_err;
  logic       w_set_err;
  logic       w_sel_d;
  logic       w_sel_i;
  logic       w_tmr_en;
  logic       w_tmr_clr;
  logic       w_expire;

  // Data always wins; a fetch only goes out when nothing blocks it.
  assign w_sel_d = io_bus.dm_req;
  assign w_sel_i = io_bus.if_req & ~io_bus.dm_req & ~i_flush & ~i_halt;

  assign w_tmr_en  = arb_is_waiting(r_state);
  assign w_tmr_clr = (w_state_nxt != r_state);

  rv32_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_set_err) begin
      r_timeout_err <= 1'b1;
    end
  end

  // Next state, request mux toward memory and response demux toward the core.
  always_comb begin
    w_state_nxt      = r_state;
    w_set_err        = 1'b0;
    io_bus.mem_req   = 1'b0;
    io_bus.mem_we    = 1'b0;
    io_bus.mem_be    = '0;
    io_bus.mem_addr  = '0;
    io_bus.mem_wdata = '0;
    io_bus.if_gnt    = 1'b0;
    io_bus.if_rvalid = 1'b0;
    io_bus.if_rdata  = '0;
    io_bus.dm_gnt    = 1'b0;
    io_bus.dm_rvalid = 1'b0;
    io_bus.dm_rdata  = '0;

    case (r_state)
      IDLE: begin
        // A late response with nothing outstanding is ignored here.
        if (w_sel_d) begin
          io_bus.mem_req   = 1'b1;
          io_bus.mem_we    = io_bus.dm_we;
          io_bus.mem_be    = io_bus.dm_be;
          io_bus.mem_addr  = io_bus.dm_addr;
          io_bus.mem_wdata = io_bus.dm_wdata;
          if (io_bus.mem_gnt) begin
            io_bus.dm_gnt = 1'b1;
            w_state_nxt   = WAIT_D;
          end
        end else if (w_sel_i) begin
          io_bus.mem_req  = 1'b1;
          io_bus.mem_be   = '1;
          io_bus.mem_addr = io_bus.if_addr;
          if (io_bus.mem_gnt) begin
            io_bus.if_gnt = 1'b1;
            w_state_nxt   = WAIT_I;
          end
        end
      end

      WAIT_I: begin
        if (io_bus.mem_rvalid) begin
          // A flush in the response cycle makes the instruction stale.
          if (!i_flush) begin
            io_bus.if_rvalid = 1'b1;
            io_bus.if_rdata  = io_bus.mem_rdata;
          end
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_set_err = 1'b1;
          if (!i_flush) begin
            io_bus.if_rvalid = 1'b1;
          end
          w_state_nxt = IDLE;
        end else if (i_flush) begin
          w_state_nxt = DROP;
        end
      end

      WAIT_D: begin
        if (io_bus.mem_rvalid) begin
          io_bus.dm_rvalid = 1'b1;
          io_bus.dm_rdata  = io_bus.mem_rdata;
          w_state_nxt      = IDLE;
        end else if (w_expire) begin
          w_set_err        = 1'b1;
          io_bus.dm_rvalid = 1'b1;
          w_state_nxt      = IDLE;
        end
      end

      DROP: begin
        // Swallow the response of the flushed fetch.
        if (io_bus.mem_rvalid) begin
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_set_err   = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_stall = (io_bus.dm_req & ~io_bus.dm_rvalid)
                 | (io_bus.if_req & ~io_bus.if_rvalid & ~i_flush & ~i_halt);
  assign o_busy        = arb_is_waiting(r_state);
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Scoreboard bench: directed scenarios plus randomized traffic against a memory/reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32_mem_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst, flush, halt;
  logic stall, busy, terr;

  rv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_halt        (halt),
    .io_bus        (bus),
    .o_stall       (stall),
    .o_busy        (busy),
    .o_timeout_err (terr)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];

  // Memory model state
  bit          auto_mem = 1'b0;
  logic        man_gnt, man_rvalid;
  logic [31:0] man_rdata;
  logic [31:0] phys[logic [31:0]];
  logic [31:0] ref_dm[logic [31:0]];
  bit          m_pend;
  int          m_cd;
  logic [31:0] m_resp;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory: manual replay for directed cases, random grant/latency otherwise.
  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    m_pend = 1'b0; m_cd = 0; m_resp = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_mem) begin
        bus.mem_gnt = man_gnt; bus.mem_rvalid = man_rvalid; bus.mem_rdata = man_rdata;
        m_pend = 1'b0;
      end else begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        if (m_pend) begin
          if (m_cd == 0) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = m_resp; m_pend = 1'b0;
          end else begin
            m_cd--;
          end
        end else begin
          bus.mem_gnt = ($urandom_range(0, 3) != 0);
          if (bus.mem_req && bus.mem_gnt) begin
            m_pend = 1'b1;
            m_cd   = int'($urandom_range(0, 3));
            if (bus.mem_we) begin
              phys[bus.mem_addr] = merge_be(phys.exists(bus.mem_addr) ? phys[bus.mem_addr] : 32'h0,
                                            bus.mem_wdata, bus.mem_be);
              m_resp = '0;
            end else begin
              m_resp = phys.exists(bus.mem_addr) ? phys[bus.mem_addr] : 32'h0;
            end
          end
        end
      end
    end
  end

  // Monitor: pops expected responses whenever the arbiter presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.if_rvalid) begin
          if (exp_if_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL if_resp_unexpected: got rdata 0x%08h expected no response at %0t",
                     bus.if_rdata, $time);
          end else chk32("if_rdata", bus.if_rdata, exp_if_q.pop_front());
        end else chk32("if_rdata_idle", bus.if_rdata, 32'h0);
        if (bus.dm_rvalid) begin
          if (exp_dm_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL dm_resp_unexpected: got rdata 0x%08h expected no response at %0t",
                     bus.dm_rdata, $time);
          end else chk32("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
        end else chk32("dm_rdata_idle", bus.dm_rdata, 32'h0);
        chk1("stall_rule", stall, (bus.dm_req & ~bus.dm_rvalid) |
                                  (bus.if_req & ~bus.if_rvalid & ~flush & ~halt));
        chk1("gnt_exclusive", bus.if_gnt & bus.dm_gnt, 1'b0);
        if (bus.if_gnt) chk1("if_gnt_priority", bus.dm_req | flush | halt, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    bit          if_done, dm_done;
    logic [31:0] a, wd;
    logic [3:0]  be;

    rst = 1'b1; flush = 1'b0; halt = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    for (int i = 0; i < 64; i++) phys[32'(i*4)] = imem_word(32'(i*4));

    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mon_en = 1'b1;
    smp();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_terr", terr, 1'b0);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_if_gnt", bus.if_gnt, 1'b0);
    chk1("rst_dm_gnt", bus.dm_gnt, 1'b0);

    // 1: single fetch, response two cycles after grant
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h10; man_gnt = 1'b1;
    exp_if_q.push_back(32'h0050_0093);
    smp();
    chk1("t1_if_gnt", bus.if_gnt, 1'b1);
    chk1("t1_mem_req", bus.mem_req, 1'b1);
    chk32("t1_mem_addr", bus.mem_addr, 32'h10);
    chk1("t1_mem_we", bus.mem_we, 1'b0);
    chk32("t1_mem_be", 32'(bus.mem_be), 32'hF);
    chk1("t1_busy_issue", busy, 1'b0);
    step(); man_gnt = 1'b0;
    smp();
    chk1("t1_if_gnt_pulse", bus.if_gnt, 1'b0);
    chk1("t1_mem_req_wait", bus.mem_req, 1'b0);
    chk1("t1_busy_w1", busy, 1'b1);
    step(); man_rvalid = 1'b1; man_rdata = 32'h0050_0093;
    smp();
    chk1("t1_if_rvalid", bus.if_rvalid, 1'b1);
    chk1("t1_busy_w2", busy, 1'b1);
    step(); bus.if_req = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    smp();
    chk1("t1_busy_done", busy, 1'b0);

    // 2: simultaneous fetch and load, data first
    step();
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h100;
    man_gnt = 1'b1;
    exp_dm_q.push_back(32'hCAFE_0001);
    exp_if_q.push_back(32'h0000_1111);
    smp();
    chk1("t2_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("t2_if_gnt_blocked", bus.if_gnt, 1'b0);
    chk32("t2_mem_addr_dm", bus.mem_addr, 32'h100);
    chk1("t2_stall_c0", stall, 1'b1);
    step(); man_gnt = 1'b0;
    smp();
    chk1("t2_stall_c1", stall, 1'b1);
    step(); man_rvalid = 1'b1; man_rdata = 32'hCAFE_0001;
    smp();
    chk1("t2_dm_rvalid", bus.dm_rvalid, 1'b1);
    chk1("t2_if_gnt_not_yet", bus.if_gnt, 1'b0);
    chk1("t2_stall_c2", stall, 1'b1);
    step(); bus.dm_req = 1'b0; man_rvalid = 1'b0; man_rdata = '0; man_gnt = 1'b1;
    smp();
    chk1("t2_if_gnt_after", bus.if_gnt, 1'b1);
    chk32("t2_mem_addr_if", bus.mem_addr, 32'h20);
    chk1("t2_stall_c3", stall, 1'b1);
    step(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_1111;
    smp();
    chk1("t2_if_rvalid", bus.if_rvalid, 1'b1);
    step(); bus.if_req = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

    // 3: fetch flushed after grant, late response dropped
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h30; man_gnt = 1'b1;
    smp();
    chk1("t3_if_gnt", bus.if_gnt, 1'b1);
    step(); bus.if_req = 1'b0; flush = 1'b1; man_gnt = 1'b0;
    smp();
    chk1("t3_stall_flush", stall, 1'b0);
    step(); flush = 1'b0;
    smp();
    chk1("t3_busy_drop1", busy, 1'b1);
    step();
    smp();
    chk1("t3_busy_drop2", busy, 1'b1);
    step(); man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    smp();
    chk1("t3_if_rvalid_suppressed", bus.if_rvalid, 1'b0);
    step(); man_rvalid = 1'b0; man_rdata = '0;
    smp();
    chk1("t3_busy_idle", busy, 1'b0);

    // 4: halt blocks fetch, store still served
    step(); halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h40;
    smp();
    chk1("t4_mem_req_halt", bus.mem_req, 1'b0);
    chk1("t4_stall_halt", stall, 1'b0);
    step();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
    bus.dm_addr = 32'h200; bus.dm_wdata = 32'h1234_5678; man_gnt = 1'b1;
    exp_dm_q.push_back(32'h0);
    smp();
    chk1("t4_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("t4_mem_we", bus.mem_we, 1'b1);
    chk32("t4_mem_be", 32'(bus.mem_be), 32'h3);
    chk32("t4_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    chk32("t4_mem_addr", bus.mem_addr, 32'h200);
    step(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = '0;
    smp();
    chk1("t4_dm_ack", bus.dm_rvalid, 1'b1);
    step(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; man_rvalid = 1'b0; man_gnt = 1'b1;
    smp();
    chk1("t4_mem_req_still_halted", bus.mem_req, 1'b0);
    step(); halt = 1'b0; bus.if_req = 1'b0; man_gnt = 1'b0;
    bus.dm_be = '0; bus.dm_wdata = '0;

    // 5: load with no response times out
    step(); bus.dm_req = 1'b1; bus.dm_be = 4'hF; bus.dm_addr = 32'h300; man_gnt = 1'b1;
    exp_dm_q.push_back(32'h0);
    smp();
    chk1("t5_dm_gnt", bus.dm_gnt, 1'b1);
    seen = 0;
    for (int k = 1; k <= TMO + 2; k++) begin
      step(); man_gnt = 1'b0;
      if (seen != 0) bus.dm_req = 1'b0;
      smp();
      if (bus.dm_rvalid && seen == 0) seen = k;
    end
    chk32("t5_timeout_cycle", 32'(seen), 32'(TMO));
    chk1("t5_terr_set", terr, 1'b1);
    chk1("t5_busy_idle", busy, 1'b0);
    repeat (3) step();
    smp();
    chk1("t5_terr_sticky", terr, 1'b1);

    // 6: reset mid-transaction, stray response ignored
    step(); bus.dm_req = 1'b1; bus.dm_addr = 32'h400; man_gnt = 1'b1;
    smp();
    chk1("t6_dm_gnt", bus.dm_gnt, 1'b1);
    step(); man_gnt = 1'b0; rst = 1'b1;
    smp();
    chk1("t6_busy_before_rst", busy, 1'b1);
    step(); rst = 1'b0; bus.dm_req = 1'b0;
    smp();
    chk1("t6_busy_after_rst", busy, 1'b0);
    chk1("t6_terr_cleared", terr, 1'b0);
    step(); man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    smp();
    chk1("t6_stray_dm", bus.dm_rvalid, 1'b0);
    chk1("t6_stray_if", bus.if_rvalid, 1'b0);
    step(); man_rvalid = 1'b0; man_rdata = '0;

    // Random traffic: disjoint fetch and data regions, random halt, random memory timing
    auto_mem = 1'b1;
    if_done = 1'b0; dm_done = 1'b0;
    for (int cyc = 0; cyc < 3000 + 200; cyc++) begin
      step();
      if (if_done) begin bus.if_req = 1'b0; if_done = 1'b0; end
      if (dm_done) begin bus.dm_req = 1'b0; dm_done = 1'b0; end
      if (cyc >= 3000) begin
        halt = 1'b0;
        if (!bus.if_req && !bus.dm_req && exp_if_q.size() == 0 && exp_dm_q.size() == 0) break;
      end else begin
        halt = ($urandom_range(0, 7) == 0);
        if (!bus.if_req && $urandom_range(0, 2) == 0) begin
          a = 32'($urandom_range(0, 63)) << 2;
          bus.if_req = 1'b1; bus.if_addr = a;
          exp_if_q.push_back(imem_word(a));
        end
        if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
          a  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
          be = 4'($urandom_range(1, 15));
          wd = $urandom;
          bus.dm_req = 1'b1; bus.dm_addr = a; bus.dm_be = be;
          if ($urandom_range(0, 1) == 1) begin
            bus.dm_we = 1'b1; bus.dm_wdata = wd;
            ref_dm[a] = merge_be(ref_dm.exists(a) ? ref_dm[a] : 32'h0, wd, be);
            exp_dm_q.push_back(32'h0);
          end else begin
            bus.dm_we = 1'b0; bus.dm_wdata = '0;
            exp_dm_q.push_back(ref_dm.exists(a) ? ref_dm[a] : 32'h0);
          end
        end
      end
      smp();
      if (bus.if_rvalid) if_done = 1'b1;
      if (bus.dm_rvalid) dm_done = 1'b1;
    end
    smp();
    chk32("rand_if_pending", 32'(exp_if_q.size()), 32'h0);
    chk32("rand_dm_pending", 32'(exp_dm_q.size()), 32'h0);
    chk1("rand_no_timeout", terr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
